vga_timing_gen: RTL and testbench

Parametrised VGA timing generator and pixel pipeline for the DE10-Lite. It replaces the fixed-800x600 red-screen driver. Horizontal and vertical timing, sync polarity, pixel-clock division and colour depth are all parameters. It issues coordinate requests to a framebuffer one pixel-tick ahead, aligns the returned pixels with HS/VS, and offers built-in test-pattern modes plus underflow detection.

---
 rtl/vga_timing_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: sync counters, a framebuffer request pipeline
// with one tick of read latency, built-in test patterns and sticky underflow flag.
module vga_timing_gen #(
    parameter int              H_ACTIVE  = 800,
    parameter int              H_FP      = 56,
    parameter int              H_SYNC    = 120,
    parameter int              H_BP      = 64,
    parameter int              V_ACTIVE  = 600,
    parameter int              V_FP      = 37,
    parameter int              V_SYNC    = 6,
    parameter int              V_BP      = 23,
    parameter bit              HS_POL    = 1'b1,
    parameter bit              VS_POL    = 1'b1,
    parameter int              CLK_DIV   = 1,
    parameter int              CW        = 4,
    parameter int              XW        = 11,
    parameter int              YW        = 10,
    parameter logic [3*CW-1:0] SOLID_RGB = 12'hF00
) (
    input  logic              MAX10_CLK1_50,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [3*CW-1:0]   pix_rgb,
    input  logic              pix_valid,
    input  logic              underflow_clr,
    output logic              req_o,
    output logic [XW-1:0]     req_x,
    output logic [YW-1:0]     req_y,
    output logic              frame_start_o,
    output logic              underflow_o,
    output logic [CW-1:0]     VGA_R,
    output logic [CW-1:0]     VGA_G,
    output logic [CW-1:0]     VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int RGB_W   = 3 * CW;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [XW-1:0] BAR_X    = XW'(BAR_W);

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [RGB_W-1:0] bar_rgb(input logic [XW-1:0] x);
        logic [XW-1:0] bar;
        logic [2:0]    c;
        bar = x / BAR_X;
        c   = 3'b000;
        if (bar <= XW'(7)) begin
            case (bar[2:0])
                3'd0:    c = 3'b111;
                3'd1:    c = 3'b110;
                3'd2:    c = 3'b011;
                3'd3:    c = 3'b010;
                3'd4:    c = 3'b101;
                3'd5:    c = 3'b100;
                3'd6:    c = 3'b001;
                default: c = 3'b000;
            endcase
        end
        return {{CW{c[2]}}, {CW{c[1]}}, {CW{c[0]}}};
    endfunction

    function automatic logic [RGB_W-1:0] pixel_rgb(input logic             act,
                                                   input logic [1:0]       m,
                                                   input logic             got_pix,
                                                   input logic [RGB_W-1:0] prgb,
                                                   input logic [XW-1:0]    x);
        logic [RGB_W-1:0] c;
        c = '0;
        if (act) begin
            case (m)
                2'd0:    c = got_pix ? prgb : '0;
                2'd1:    c = SOLID_RGB;
                2'd2:    c = bar_rgb(x);
                default: c = '0;
            endcase
        end
        return c;
    endfunction

    logic [DW-1:0]    div;
    logic             tick;
    logic [XW-1:0]    h_p0;
    logic [YW-1:0]    v_p0;
    logic [1:0]       mode_r;
    logic [1:0]       mode_cur;
    logic             origin_p0, act_p0, hs_p0, vs_p0;
    logic             vld_p1, act_p1, hs_p1, vs_p1;
    logic [XW-1:0]    x_p1;
    logic [YW-1:0]    y_p1;
    logic [1:0]       mode_p1;
    logic             vld_p2, act_p2, hs_p2, vs_p2;
    logic [XW-1:0]    x_p2;
    logic [1:0]       mode_p2;
    logic [RGB_W-1:0] rgb_p3;
    logic             hs_p3, vs_p3;
    logic             uf_set;

    assign tick      = (div == DIV_LAST);
    assign origin_p0 = (h_p0 == '0) && (v_p0 == '0);
    // The new mode only takes effect as pixel (0,0) enters the pipeline.
    assign mode_cur  = origin_p0 ? mode : mode_r;
    assign act_p0    = (h_p0 < H_ACT) && (v_p0 < V_ACT);
    assign hs_p0     = (h_p0 >= HS_BEG) && (h_p0 <= HS_END);
    assign vs_p0     = (v_p0 >= VS_BEG) && (v_p0 <= VS_END);
    assign uf_set    = tick && vld_p2 && !pix_valid;

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Stage p0: raster counters
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            h_p0   <= '0;
            v_p0   <= '0;
            mode_r <= 2'd0;
        end else if (tick) begin
            mode_r <= mode_cur;
            if (h_p0 == H_LAST) begin
                h_p0 <= '0;
                v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + 1'b1;
            end else begin
                h_p0 <= h_p0 + 1'b1;
            end
        end
    end

    // Stage p1: request to the framebuffer
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            act_p1  <= 1'b0;
            hs_p1   <= 1'b0;
            vs_p1   <= 1'b0;
            x_p1    <= '0;
            y_p1    <= '0;
            mode_p1 <= 2'd0;
        end else if (tick) begin
            vld_p1  <= act_p0 && (mode_cur == 2'd0);
            act_p1  <= act_p0;
            hs_p1   <= hs_p0;
            vs_p1   <= vs_p0;
            x_p1    <= h_p0;
            y_p1    <= v_p0;
            mode_p1 <= mode_cur;
        end
    end

    // Stage p2: wait one tick for the source's read data
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            act_p2  <= 1'b0;
            hs_p2   <= 1'b0;
            vs_p2   <= 1'b0;
            x_p2    <= '0;
            mode_p2 <= 2'd0;
        end else if (tick) begin
            vld_p2  <= vld_p1;
            act_p2  <= act_p1;
            hs_p2   <= hs_p1;
            vs_p2   <= vs_p1;
            x_p2    <= x_p1;
            mode_p2 <= mode_p1;
        end
    end

    // Stage p3: DAC and sync pins
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            rgb_p3 <= '0;
            hs_p3  <= ~HS_POL;
            vs_p3  <= ~VS_POL;
        end else if (tick) begin
            rgb_p3 <= pixel_rgb(act_p2, mode_p2, vld_p2 && pix_valid, pix_rgb, x_p2);
            hs_p3  <= hs_p2 ? HS_POL : ~HS_POL;
            vs_p3  <= vs_p2 ? VS_POL : ~VS_POL;
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_o <= 1'b0;
            underflow_o   <= 1'b0;
        end else begin
            frame_start_o <= tick && origin_p0;
            if (uf_set) begin
                underflow_o <= 1'b1;
            end else if (underflow_clr) begin
                underflow_o <= 1'b0;
            end
        end
    end

    assign req_o  = vld_p1;
    assign req_x  = x_p1;
    assign req_y  = y_p1;
    assign VGA_R  = rgb_p3[RGB_W-1 -: CW];
    assign VGA_G  = rgb_p3[2*CW-1 -: CW];
    assign VGA_B  = rgb_p3[CW-1:0];
    assign VGA_HS = hs_p3;
    assign VGA_VS = vs_p3;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a small raster: every clock is compared
// against a position-based model of requests, pins, frame_start and underflow.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
    localparam int VA = 6, VF = 1, VSY = 2, VB = 1;
    localparam int DIV = 3, CW = 4, XW = 8, YW = 6;
    localparam bit HP = 1'b0, VP = 1'b1;
    localparam logic [11:0] SOLID = 12'h5A3;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FR = HT * VT;
    localparam int NDROP = 8192;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic [11:0]   pix_rgb;
    logic          pix_valid;
    logic          underflow_clr;
    logic          req_o;
    logic [XW-1:0] req_x;
    logic [YW-1:0] req_y;
    logic          frame_start_o;
    logic          underflow_o;
    logic [CW-1:0] VGA_R, VGA_G, VGA_B;
    logic          VGA_HS, VGA_VS;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP), .CLK_DIV(DIV), .CW(CW),
        .XW(XW), .YW(YW), .SOLID_RGB(SOLID)
    ) dut (
        .MAX10_CLK1_50(clk),
        .rst_n(rst_n),
        .mode(mode),
        .pix_rgb(pix_rgb),
        .pix_valid(pix_valid),
        .underflow_clr(underflow_clr),
        .req_o(req_o),
        .req_x(req_x),
        .req_y(req_y),
        .frame_start_o(frame_start_o),
        .underflow_o(underflow_o),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B),
        .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: clocks since reset release, mode latched per frame, dropped pixels
    int  cyc;
    int  fm [0:63];
    bit  drop_arr [0:NDROP-1];
    bit  exp_fs, exp_uf;
    int  cur_req, cur_x, cur_y, prv_req, prv_x, prv_y;
    int  mode_cnt;
    logic [11:0] bar_tab [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                   12'hF0F, 12'hF00, 12'h00F, 12'h000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d t=%0t", tag, got, exp, cyc, $time);
        end
    endtask

    function automatic int ph(input int p);
        return p % HT;
    endfunction

    function automatic int pv(input int p);
        return (p / HT) % VT;
    endfunction

    function automatic bit in_active(input int p);
        return (ph(p) < HA) && (pv(p) < VA);
    endfunction

    function automatic bit needs_pix(input int p);
        return in_active(p) && (fm[p / FR] == 0);
    endfunction

    function automatic logic [11:0] pat(input int x, input int y);
        logic [3:0] a, b;
        a = x[3:0];
        b = y[3:0];
        return {a, b, a ^ b};
    endfunction

    function automatic logic [11:0] exp_colour(input int q);
        int x, y;
        x = ph(q);
        y = pv(q);
        if (!in_active(q)) return 12'h000;
        case (fm[q / FR])
            0:       return drop_arr[q] ? 12'h000 : pat(x, y);
            1:       return SOLID;
            2:       return bar_tab[x / (HA / 8)];
            default: return 12'h000;
        endcase
    endfunction

    // Advance the model over one rising edge with rst_n high.
    task automatic model_edge();
        int n;
        bit set;
        cyc++;
        exp_fs = 1'b0;
        set    = 1'b0;
        if (cyc % DIV == 0) begin
            n = cyc / DIV;
            if ((n - 1) % FR == 0) begin
                fm[(n - 1) / FR] = int'(mode);
                exp_fs = 1'b1;
            end
            if (n >= 3) set = needs_pix(n - 3) && drop_arr[n - 3];
        end
        if (set) exp_uf = 1'b1;
        else if (underflow_clr) exp_uf = 1'b0;
    endtask

    task automatic check_all();
        int n, p, q;
        logic [11:0] e_rgb;
        logic e_hs, e_vs;
        n = cyc / DIV;
        if (n >= 1) begin
            p = n - 1;
            chk("req_o", 32'(req_o), 32'(needs_pix(p)));
            chk("req_x", 32'(req_x), 32'(ph(p)));
            chk("req_y", 32'(req_y), 32'(pv(p)));
        end else begin
            chk("req_o", 32'(req_o), 32'd0);
            chk("req_x", 32'(req_x), 32'd0);
            chk("req_y", 32'(req_y), 32'd0);
        end
        if (n >= 3) begin
            q = n - 3;
            e_rgb = exp_colour(q);
            e_hs  = (ph(q) >= HA + HF && ph(q) < HA + HF + HSY) ? HP : !HP;
            e_vs  = (pv(q) >= VA + VF && pv(q) < VA + VF + VSY) ? VP : !VP;
        end else begin
            e_rgb = 12'h000;
            e_hs  = !HP;
            e_vs  = !VP;
        end
        chk("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e_rgb));
        chk("hs", 32'(VGA_HS), 32'(e_hs));
        chk("vs", 32'(VGA_VS), 32'(e_vs));
        chk("frame_start", 32'(frame_start_o), 32'(exp_fs));
        chk("underflow", 32'(underflow_o), 32'(exp_uf));
    endtask

    // Source answers the previous period's request just before the sampling tick;
    // at every other clock it drives garbage that must be ignored.
    task automatic drive_inputs();
        int nt, pos;
        bit drop;
        if (cyc % DIV == 0) begin
            prv_req = cur_req;
            prv_x   = cur_x;
            prv_y   = cur_y;
            cur_req = int'(req_o);
            cur_x   = int'(req_x);
            cur_y   = int'(req_y);
        end
        if ((cyc + 1) % DIV == 0) begin
            nt  = cyc / DIV;
            pos = nt - 2;
            if (prv_req != 0) begin
                drop = ($urandom_range(0, 11) == 0);
                if (pos >= 0 && pos < NDROP) drop_arr[pos] = drop;
                pix_valid = !drop;
                pix_rgb   = drop ? 12'($urandom) : pat(prv_x, prv_y);
            end else begin
                pix_valid = 1'($urandom);
                pix_rgb   = 12'($urandom);
            end
        end else begin
            pix_valid = 1'($urandom);
            pix_rgb   = 12'($urandom);
        end
        underflow_clr = ($urandom_range(0, 23) == 0);
        if (mode_cnt == 0) begin
            mode     = 2'($urandom);
            mode_cnt = $urandom_range(150, 1200);
        end else begin
            mode_cnt--;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_all();
        drive_inputs();
    endtask

    task automatic model_reset();
        cyc     = 0;
        exp_fs  = 1'b0;
        exp_uf  = 1'b0;
        cur_req = 0; cur_x = 0; cur_y = 0;
        prv_req = 0; prv_x = 0; prv_y = 0;
        for (int i = 0; i < NDROP; i++) drop_arr[i] = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b1;
        mode          = 2'd1;
        pix_rgb       = '0;
        pix_valid     = 1'b0;
        underflow_clr = 1'b0;
        mode_cnt      = 0;
        for (int i = 0; i < 64; i++) fm[i] = 0;
        model_reset();

        #1 rst_n = 1'b0;
        #1 check_all();
        repeat (4) step();
        rst_n = 1'b1;
        repeat (10 * FR * DIV + 40) step();

        // Asynchronous reset in the middle of a line
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3 * FR * DIV) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
